// File: rtl/fetch_ctrl.sv
// Instruction-fetch front end: owns the fetch PC, issues word-aligned reads and
// buffers returned words with their PCs in a small queue for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_ren,
  input  logic        mem_ready,
  input  logic [31:0] mem_dataout,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {StRun, StDrain} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q, pending_pc_q;
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [PW-1:0]   head_q, tail_q, head_d, tail_d;
  logic [CW-1:0]   count_q, count_d, count_left;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic [31:0]     target;
  logic            pop, space, beat, push;
  logic            unused_rpc;

  assign target     = {redirect_pc[31:2], 2'b00};
  assign unused_rpc = ^redirect_pc[1:0];

  assign pop   = inst_valid_q && dec_ready;
  assign space = (count_q < CW'(DEPTH)) || pop;
  // A pending miss can never lose its request: only this block pushes, so space stays.
  assign mem_ren     = !reset && ((state_q == StDrain) || space);
  assign mem_address = fetch_pc_q;
  assign beat        = mem_ren && mem_ready;
  assign push        = beat && (state_q == StRun) && !redirect;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    count_left   = count_q - CW'(pop);
    head_d       = head_q + PW'(pop);
    tail_d       = tail_q;
    count_d      = count_left;
    if (push) begin
      tail_d  = tail_q + PW'(1'b1);
      count_d = count_left + CW'(1'b1);
    end
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    // Head registers hold their last value whenever the queue goes empty.
    inst_valid_d = (count_d != '0);
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (count_d != '0) begin
      if (count_left == '0) begin
        inst_d    = mem_dataout;
        inst_pc_d = fetch_pc_q;
      end else begin
        inst_d    = q_inst[head_d];
        inst_pc_d = q_pc[head_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail_q] <= mem_dataout;
      q_pc[tail_q]   <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            if (mem_ren && !mem_ready) begin
              // Miss in flight: let it finish to the old address, then retarget.
              pending_pc_q <= target;
              state_q      <= StDrain;
            end else begin
              fetch_pc_q <= target;
            end
          end else if (beat) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        StDrain: begin
          if (mem_ready) begin
            fetch_pc_q <= redirect ? target : pending_pc_q;
            state_q    <= StRun;
          end else if (redirect) begin
            pending_pc_q <= target;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address;
  logic        mem_ren;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_dataout = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_ctrl #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_ren     (mem_ren),
    .mem_ready   (mem_ready),
    .mem_dataout (mem_dataout),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] pc;
  } ent_t;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_drain = 1'b0;
  logic [31:0] m_pend = '0;
  ent_t        m_show = '0;

  // Previous-cycle bus state for the miss-hold property
  logic        p_hold = 1'b0;
  logic [31:0] p_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [31:0] d,
                       input logic rd, input logic [31:0] rp, input logic dr);
    logic        e_ren, e_valid, beat;
    logic [31:0] tgt;
    @(negedge clk);
    reset = rst; mem_ready = rdy; mem_dataout = d;
    redirect = rd; redirect_pc = rp; dec_ready = dr;
    #1;
    e_valid = (mq.size() != 0);
    e_ren   = !rst && (m_drain || mq.size() < DEPTH || (e_valid && dr));
    check("mem_ren", {31'd0, mem_ren}, {31'd0, e_ren});
    check("mem_address", mem_address, m_pc);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, e_valid});
    check("inst", inst, e_valid ? mq[0].i : m_show.i);
    check("inst_pc", inst_pc, e_valid ? mq[0].pc : m_show.pc);
    if (p_hold && !rst) begin
      check("miss_hold_ren", {31'd0, mem_ren}, 32'd1);
      check("miss_hold_addr", mem_address, p_addr);
    end
    p_hold = e_ren && !rdy;
    p_addr = m_pc;

    tgt = {rp[31:2], 2'b00};
    if (rst) begin
      mq.delete(); m_pc = RESET_PC; m_drain = 1'b0; m_show = '0;
    end else begin
      beat = e_ren && rdy;
      if (e_valid && dr) void'(mq.pop_front());
      if (rd) mq.delete();
      if (m_drain) begin
        if (rdy) begin
          m_pc = rd ? tgt : m_pend;
          m_drain = 1'b0;
        end else if (rd) begin
          m_pend = tgt;
        end
      end else if (rd) begin
        if (e_ren && !rdy) begin
          m_pend = tgt; m_drain = 1'b1;
        end else begin
          m_pc = tgt;
        end
      end else if (beat) begin
        mq.push_back('{i: d, pc: m_pc});
        m_pc = m_pc + 32'd4;
      end
      if (mq.size() != 0) m_show = mq[0];
    end
  endtask

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC000_0000 ^ a;
  endfunction

  initial begin
    // Reset
    drive(1, 1, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1);
    check("rst_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_addr", mem_address, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Streaming from reset
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("first_addr", mem_address, 32'h0);
    check("first_ren", {31'd0, mem_ren}, 32'd1);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("stream_addr4", mem_address, 32'h4);
    check("stream_pc0", inst_pc, 32'h0);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("stream_addr8", mem_address, 32'h8);
    check("stream_pc4", inst_pc, 32'h4);
    check("stream_inst4", inst, 32'hC000_0004);

    // Backpressure
    for (int k = 0; k < 5; k++) drive(0, 1, word(m_pc), 0, 0, 0);
    check("bp_ren_off", {31'd0, mem_ren}, 32'd0);
    check("bp_valid", {31'd0, inst_valid}, 32'd1);
    for (int k = 0; k < 4; k++) drive(0, 1, word(m_pc), 0, 0, 1);

    // Redirect on hit to 0x103, then a 4-cycle miss at 0x10
    drive(0, 1, word(m_pc), 1, 32'h103, 1);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("rd_valid_off", {31'd0, inst_valid}, 32'd0);
    check("rd_addr", mem_address, 32'h100);
    drive(0, 1, word(m_pc), 1, 32'h13, 1);
    check("rd_pc100", inst_pc, 32'h100);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 32'h0BAD_0BAD, 0, 0, 1);
      check("miss_addr", mem_address, 32'h10);
    end
    drive(0, 1, 32'h1234_5678, 0, 0, 1);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("miss_next_addr", mem_address, 32'h14);
    check("miss_inst_pc", inst_pc, 32'h10);
    check("miss_inst", inst, 32'h1234_5678);

    // Redirect mid-miss, second redirect in drain wins
    drive(0, 1, word(m_pc), 1, 32'h20, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 32'h200, 1);
    drive(0, 0, 0, 1, 32'h300, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 1);
    check("drain_addr", mem_address, 32'h20);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("drain_valid", {31'd0, inst_valid}, 32'd0);
    check("drain_target", mem_address, 32'h300);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("drain_inst_pc", inst_pc, 32'h300);

    // Wrap
    drive(0, 1, word(m_pc), 1, 32'hFFFF_FFFF, 1);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("wrap_addr", mem_address, 32'hFFFF_FFFC);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("wrap_zero", mem_address, 32'h0);

    // Redirect with pop
    drive(0, 1, word(m_pc), 1, 32'h400, 1);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("rdpop_empty", {31'd0, inst_valid}, 32'd0);

    // Reset during a miss
    drive(0, 1, word(m_pc), 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check("rstmiss_ren", {31'd0, mem_ren}, 32'd0);
    drive(0, 1, word(m_pc), 0, 0, 1);
    check("rstmiss_addr", mem_address, RESET_PC);
    check("rstmiss_valid", {31'd0, inst_valid}, 32'd0);
    check("rstmiss_inst", inst, 32'h0);

    // Randomized run
    for (int n = 0; n < 4000; n++) begin
      drive(($urandom_range(199) == 0), ($urandom_range(9) < 7), $urandom,
            ($urandom_range(9) == 0), $urandom, ($urandom_range(9) < 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch front end of the core, directly upstream of the instruction memory controller. Owns the fetch PC and issues word-aligned read requests to the instruction memory controller. Buffers returned instructions with their PCs in a small queue for decode. Handles branch/jump redirects, including a redirect that arrives while a cache miss is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- DEPTH, 2, instruction queue entries; power of two, ≥2

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- mem_address  out  32  byte address to instruction memory controller; always word-aligned
- mem_ren  out  1  read request to memory controller
- mem_ready  in  1  memory controller ready (its memReady); high = request done this cycle
- mem_dataout  in  32  instruction word; valid in any cycle with mem_ren && mem_ready
- redirect  in  1  one-cycle pulse from execute: control transfer taken
- redirect_pc  in  32  target; bits [1:0] ignored and treated as 0
- dec_ready  in  1  decode accepts queue head this cycle
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  32  PC of queue head

## Operation
- Registers: fetch_pc, pending_pc, queue of DEPTH {inst, pc} entries, count in 0..DEPTH, head/tail pointers, 1-bit state RUN/DRAIN.
- beat = mem_ren && mem_ready; pop = inst_valid && dec_ready; space = (count < DEPTH) || pop.
- mem_address = fetch_pc in RUN, and the held miss address in DRAIN.
- RUN:
  - mem_ren = space, except that a request raised with mem_ready low stays asserted, with mem_address unchanged, until mem_ready. Space cannot disappear, because only this block pushes.
  - On beat without redirect: push {mem_dataout, fetch_pc}; fetch_pc <= fetch_pc + 4, mod 2^32, so 32'hFFFF_FFFC wraps to 0.
  - On redirect with no miss outstanding (!mem_ren || mem_ready):
    - flush the queue (count <= 0);
    - discard any same-cycle beat;
    - fetch_pc <= {redirect_pc[31:2], 2'b00};
    - stay in RUN.
  - On redirect with mem_ren && !mem_ready (miss in flight): flush the queue; pending_pc <= aligned redirect_pc; go to DRAIN.
- DRAIN:
  - mem_ren = 1 and the address is held, so the miss completes to the old address.
  - On mem_ready: discard the word; fetch_pc <= pending_pc; go to RUN.
  - A further redirect in DRAIN overwrites pending_pc and flushes again.
  - A redirect coinciding with the mem_ready cycle uses the new redirect_pc.
- No pushes occur in DRAIN.
- Redirect with pop in the same cycle: the head handshake completes (decode consumed it), then the flush applies. Redirect takes priority over push.
- Push and pop in the same cycle: count is unchanged; a full queue still accepts the push.
- inst/inst_pc show the head entry; when count = 0 they hold their last values and inst_valid = 0.

## Timing
- Reset (sampled high at an edge), after that edge:
  - fetch_pc = RESET_PC; state RUN; count 0;
  - inst_valid 0, inst 0, inst_pc 0, mem_ren 0, mem_address RESET_PC.
- mem_ren is forced to 0 while reset is high. The first request is asserted in the first cycle with reset low.
- Reset mid-miss: the request is abandoned and the queue is flushed; no discard cycle is owed.
- Hit latency: beat in cycle N puts the entry at the queue head in N+1 (inst_valid registered). Sustained throughput is 1 instruction/cycle with dec_ready high.
- Miss: mem_ren and mem_address are held stable for every cycle of mem_ready low. The word is pushed at the edge ending the mem_ready-high cycle.
- Redirect to new-target request:
  - Redirect in cycle R with no miss: mem_address = target in R+1; first target instruction inst_valid at R+2 on a hit.
  - Redirect in DRAIN: first target request in the cycle after the drained beat.
- All outputs come from registers except mem_ren and mem_address, which are combinational from state, fetch_pc, count and dec_ready.

## Test plan
- Reset release, RESET_PC=0, mem_ready=1, dec_ready=1 -> addresses 0,4,8,... on consecutive cycles; inst_pc 0,4,8 one cycle later; no gaps.
- Backpressure: dec_ready=0 for 5 cycles, DEPTH=2 -> exactly 2 pushes, then mem_ren=0. On dec_ready=1, in-order delivery with no lost or duplicated PC.
- Miss: mem_ready low 4 cycles at address 0x10 -> mem_ren and mem_address=0x10 held for 4 cycles; word pushed with pc 0x10; next address 0x14.
- Redirect on hit: redirect_pc=0x103 in cycle R, queue holding 2 entries -> inst_valid=0 at R+1, mem_address=0x100 at R+1, inst_pc=0x100 at R+2.
- Redirect mid-miss at 0x20, mem_ready rises 3 cycles later with word 0xDEAD_BEEF -> 0xDEAD_BEEF never valid. Next request is to the target. A second redirect during DRAIN wins.
- Wrap and coincidences: fetch_pc=0xFFFF_FFFC -> next 0x0. Redirect plus pop in the same cycle -> head consumed once, queue empty next cycle. Reset asserted during a miss -> outputs at reset values next cycle.
